// File: rtl/test_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : test_pattern_gen
// Description : Video test pattern generator. Draws a ZX-style screen made of
//               a yellow outer border, a magenta inner border and a paper
//               area. The paper shows one of four patterns: RGB gradient
//               bands, colour bars, a checkerboard or a scrolling gradient.
//               The pixel colour and the syncs are registered, so both
//               appear one clock after the hc/vc/sync inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module test_pattern_gen #(
  parameter int HRES    = 800,
  parameter int VRES    = 600,
  parameter int ZXW     = 704,
  parameter int ZXH     = 576,
  parameter int PAPERW  = 512,
  parameter int PAPERH  = 384,
  parameter int CW      = 8,
  parameter int SQ_LOG2 = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [10:0]   hc,
  input  logic [10:0]   vc,
  input  logic          hs_in,
  input  logic          vs_in,
  input  logic [1:0]    mode,
  input  logic          pause,
  output logic [CW-1:0] r,
  output logic [CW-1:0] g,
  output logic [CW-1:0] b,
  output logic          hs_out,
  output logic          vs_out,
  output logic [7:0]    frame_cnt
);

  // --------------------------------------------------------------------------
  // Geometry. Every region is centred in the visible area. All region tests
  // subtract the region origin and do one unsigned compare, so coordinates
  // left of or above the origin wrap to large values and fall outside.
  // --------------------------------------------------------------------------
  localparam int ZX0X    = (HRES - ZXW) / 2;
  localparam int ZX0Y    = (VRES - ZXH) / 2;
  localparam int PX0     = (HRES - PAPERW) / 2;
  localparam int PY0     = (VRES - PAPERH) / 2;
  localparam int PW_LOG2 = $clog2(PAPERW);
  localparam int BAND_H  = PAPERH / 3;

  localparam logic [10:0] C_HRES   = 11'(HRES);
  localparam logic [10:0] C_VRES   = 11'(VRES);
  localparam logic [10:0] C_ZX0X   = 11'(ZX0X);
  localparam logic [10:0] C_ZX0Y   = 11'(ZX0Y);
  localparam logic [10:0] C_ZXW    = 11'(ZXW);
  localparam logic [10:0] C_ZXH    = 11'(ZXH);
  localparam logic [10:0] C_PX0    = 11'(PX0);
  localparam logic [10:0] C_PY0    = 11'(PY0);
  localparam logic [10:0] C_PAPERW = 11'(PAPERW);
  localparam logic [10:0] C_PAPERH = 11'(PAPERH);
  localparam logic [10:0] C_BAND1  = 11'(BAND_H);
  localparam logic [10:0] C_BAND2  = 11'(2 * BAND_H);

  localparam logic [1:0] MODE_GRADIENT = 2'd0;
  localparam logic [1:0] MODE_BARS     = 2'd1;
  localparam logic [1:0] MODE_CHECKER  = 2'd2;
  localparam logic [1:0] MODE_SCROLL   = 2'd3;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [CW-1:0] r_q, g_q, b_q;
  logic [CW-1:0] r_d, g_d, b_d;
  logic          hs_q, vs_q;
  logic [7:0]    frame_cnt_q;
  logic [7:0]    frame_cnt_d;
  logic [1:0]    mode_q;
  logic [1:0]    mode_d;

  // --------------------------------------------------------------------------
  // Position decode
  // --------------------------------------------------------------------------
  logic [10:0] w_x;
  logic [10:0] w_y;
  logic [10:0] w_zx_x;
  logic [10:0] w_zx_y;
  logic        w_visible;
  logic        w_in_zx;
  logic        w_in_paper;
  logic        w_frame_start;

  assign w_x           = hc - C_PX0;
  assign w_y           = vc - C_PY0;
  assign w_zx_x        = hc - C_ZX0X;
  assign w_zx_y        = vc - C_ZX0Y;
  assign w_visible     = (hc < C_HRES) && (vc < C_VRES);
  assign w_in_zx       = (w_zx_x < C_ZXW) && (w_zx_y < C_ZXH);
  assign w_in_paper    = (w_x < C_PAPERW) && (w_y < C_PAPERH);
  assign w_frame_start = (hc == 11'd0) && (vc == 11'd0);

  // --------------------------------------------------------------------------
  // Frame counter resized to the gradient width so the scroll sum wraps
  // modulo 2^(CW+1); this keeps the scrolling seam invisible.
  // --------------------------------------------------------------------------
  logic [CW:0] w_fc_ext;

  generate
    if (CW + 1 > 8) begin : g_fc_pad
      assign w_fc_ext = {{(CW + 1 - 8){1'b0}}, frame_cnt_q};
    end else if (CW + 1 == 8) begin : g_fc_same
      assign w_fc_ext = frame_cnt_q;
    end else begin : g_fc_trunc
      assign w_fc_ext = frame_cnt_q[CW:0];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Paper pattern building blocks
  // --------------------------------------------------------------------------
  logic [CW-1:0] w_grad_v;
  logic [CW-1:0] w_scroll_v;
  logic [CW-1:0] w_ramp_v;
  logic [1:0]    w_band;
  logic [2:0]    w_bar_idx;
  logic          w_checker;

  assign w_grad_v   = w_x[CW:1];
  assign w_scroll_v = CW'((w_x[CW:0] + w_fc_ext) >> 1);
  assign w_ramp_v   = (mode_q == MODE_SCROLL) ? w_scroll_v : w_grad_v;
  assign w_bar_idx  = w_x[PW_LOG2-1 -: 3];
  assign w_checker  = w_x[SQ_LOG2] ^ w_y[SQ_LOG2];

  // Which third of the paper the current line belongs to
  always_comb begin
    if (w_y < C_BAND1) begin
      w_band = 2'd0;
    end else if (w_y < C_BAND2) begin
      w_band = 2'd1;
    end else begin
      w_band = 2'd2;
    end
  end

  // Colour for the current hc/vc, using the mode latched at frame start
  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (!w_visible) begin
      r_d = '0;
    end else if (!w_in_zx) begin
      r_d = '1;
      g_d = '1;
    end else if (!w_in_paper) begin
      r_d = '1;
      b_d = '1;
    end else begin
      case (mode_q)
        MODE_GRADIENT, MODE_SCROLL: begin
          case (w_band)
            2'd0:    r_d = w_ramp_v;
            2'd1:    g_d = w_ramp_v;
            default: b_d = w_ramp_v;
          endcase
        end
        MODE_BARS: begin
          r_d = w_bar_idx[1] ? '0 : '1;
          g_d = w_bar_idx[2] ? '0 : '1;
          b_d = w_bar_idx[0] ? '0 : '1;
        end
        MODE_CHECKER: begin
          if (!w_checker) begin
            r_d = '1;
            g_d = '1;
            b_d = '1;
          end
        end
        default: begin
          r_d = '0;
        end
      endcase
    end
  end

  // Frame-start bookkeeping: mode and counter only move on hc==0, vc==0
  always_comb begin
    mode_d      = mode_q;
    frame_cnt_d = frame_cnt_q;
    if (w_frame_start) begin
      mode_d = mode;
      if (!pause) begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
    end
  end

  // Output pipeline stage: colour and syncs share the same single clock delay
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
      hs_q <= 1'b1;
      vs_q <= 1'b1;
    end else begin
      r_q  <= r_d;
      g_q  <= g_d;
      b_q  <= b_d;
      hs_q <= hs_in;
      vs_q <= vs_in;
    end
  end

  // Frame state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q      <= MODE_GRADIENT;
      frame_cnt_q <= 8'd0;
    end else begin
      mode_q      <= mode_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign r         = r_q;
  assign g         = g_q;
  assign b         = b_q;
  assign hs_out    = hs_q;
  assign vs_out    = vs_q;
  assign frame_cnt = frame_cnt_q;

endmodule
`default_nettype wire

// File: doc/test_pattern_gen.md
TEST_PATTERN_GEN -- requirements
Module: test_pattern_gen

Interface
REQ-001 Parameter HRES, default 800, visible pixels per line.
REQ-002 Parameter VRES, default 600, visible lines per frame.
REQ-003 Parameter ZXW, default 704, width of the ZX display area (paper plus inner border), centred.
REQ-004 Parameter ZXH, default 576, height of the ZX display area, centred.
REQ-005 Parameter PAPERW, default 512, paper width, centred; power of two, >= 8.
REQ-006 Parameter PAPERH, default 384, paper height, centred; divisible by 3.
REQ-007 Parameter CW, default 8, colour channel width; PAPERW >= 2^(CW+1) is a legal configuration requirement.
REQ-008 Parameter SQ_LOG2, default 5, log2 of the checkerboard square size.
REQ-009 clk  in  1  pixel clock; the only clock.
REQ-010 rst  in  1  asynchronous, active-high reset.
REQ-011 hc  in  11  horizontal counter from the sync generator.
REQ-012 vc  in  11  vertical counter from the sync generator.
REQ-013 hs_in, vs_in  in  1 each  raw syncs from the sync generator, active-low.
REQ-014 mode  in  2  pattern select: 0 = gradient, 1 = colour bars, 2 = checkerboard, 3 = scrolling gradient.
REQ-015 pause  in  1  when 1, the frame counter holds.
REQ-016 r, g, b  out  CW each  registered pixel colour.
REQ-017 hs_out, vs_out  out  1 each  syncs delayed to match colour latency.
REQ-018 frame_cnt  out  8  frame counter.

Function
REQ-019 Define ZX0X=(HRES-ZXW)/2, ZX0Y=(VRES-ZXH)/2, PX0=(HRES-PAPERW)/2, PY0=(VRES-PAPERH)/2, x=hc-PX0, y=vc-PY0 (11-bit wrap).
REQ-020 Latency SHALL be exactly 1 clock: r/g/b, hs_out and vs_out at cycle n+1 reflect hc/vc/hs_in/vs_in at cycle n.
REQ-021 hc>=HRES or vc>=VRES: colour SHALL be all zeros.
REQ-022 Visible but outside the ZX area: colour SHALL be yellow (R=G=all ones, B=0).
REQ-023 Inside the ZX area but outside the paper: colour SHALL be magenta (R=B=all ones, G=0).
REQ-024 Paper region, all modes, uses the latched mode (mode_q), never the live mode input.
REQ-025 Mode 0: v = x[CW:1]; band = y/(PAPERH/3); band 0 -> (v,0,0), band 1 -> (0,v,0), band 2 -> (0,0,v).
REQ-026 Mode 1: i = x*8/PAPERW (top 3 bits of x); R = all ones iff i[1]=0, G = all ones iff i[2]=0, B = all ones iff i[0]=0 (white, yellow, cyan, green, magenta, red, blue, black).
REQ-027 Mode 2: x[SQ_LOG2] XOR y[SQ_LOG2] = 0 -> all ones on R, G, B; = 1 -> all zeros.
REQ-028 Mode 3: as mode 0 but v = (x + frame_cnt)[CW:1], the addition modulo 2^(CW+1); wrap-around SHALL be seamless.
REQ-029 Frame start is the cycle with hc==0 and vc==0.
REQ-030 At frame start, mode_q SHALL load mode; the new mode applies from the next cycle's input pixel.
REQ-031 At frame start with pause=0, frame_cnt SHALL increment, wrapping 255->0; with pause=1 it holds.
REQ-032 mode or pause changes away from frame start SHALL have no effect until the next frame start.
REQ-033 frame_cnt SHALL only change at frame start; arbitrary hc/vc jumps elsewhere SHALL not corrupt it.

Reset
REQ-034 rst=1 SHALL immediately force: r=g=b=0, hs_out=vs_out=1, frame_cnt=0, mode_q=0.
REQ-035 Reset mid-frame: after release, outputs resume on the next clock from current hc/vc, using mode_q=0 until the next frame start.

Verification
REQ-036 Mode 0 latched; hc=164, vc=108 -> next cycle r=0x0A, g=0, b=0; hc=164, vc=236 -> g=0x0A, r=b=0.
REQ-037 Border: hc=10, vc=300 -> (FF,FF,00); hc=100, vc=50 -> (FF,00,FF); hc=850, vc=300 -> (00,00,00); each one cycle later.
REQ-038 Mode 1 latched; hc=208 (x=64) -> (FF,FF,00); hc=592 (x=448) -> (00,00,00).
REQ-039 Mode 2 latched; hc=176, vc=108 (x=32, y=0) -> (00,00,00); hc=144, vc=108 -> (FF,FF,FF).
REQ-040 Mode 3, pause=0, three frame starts from reset (frame_cnt=3); hc=164, vc=108 -> r=0x0B; frame_cnt 255 -> 0 at next frame start; pause=1 holds it.
REQ-041 Change mode mid-frame, then assert rst mid-frame: paper colour unchanged until frame start; reset forces all outputs to reset values asynchronously.
